// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the 32x8192 SRAM host controller.
package sram_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 13;

  // The merge helper works on a generous fixed width; callers extend/truncate.
  localparam int unsigned MERGE_MAX_W = 1024;
  localparam int unsigned MERGE_MAX_B = MERGE_MAX_W / 8;

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WAIT, RMW_WR} ctrl_state_t;

  typedef enum logic {OP_HOST_RD, OP_RMW_RD} op_kind_t;

  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_B-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MERGE_MAX_B; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_32x8192_host_ctrl_fifo.sv
// Synchronous show-ahead response FIFO with occupancy count.
module sram_rsp_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk0,
  input  logic                          rst0,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic                          valid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && valid;
  assign do_push = push && (count != CW'(DEPTH));

  always_ff @(posedge clk0) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_32x8192_host_ctrl.sv
// Host request/response front end for the 32x8192 single-port SRAM macro,
// with read-modify-write for byte-masked writes.
module sram_32x8192_host_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                    clk0,
  input  logic                    rst0,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    busy,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  input  logic [DATA_WIDTH-1:0]   sram_dout0
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  ctrl_state_t             state;
  logic                    s1_valid;
  op_kind_t                s1_kind;
  logic                    s2_valid;
  op_kind_t                s2_kind;
  logic [DATA_WIDTH-1:0]   rmw_wdata;
  logic [DATA_WIDTH/8-1:0] rmw_wmask;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    accept;
  int unsigned             credit_used;

  // Every accepted host read holds a FIFO slot from accept until it is popped.
  always_comb begin
    credit_used = 32'(fifo_count);
    if (s1_valid && s1_kind == OP_HOST_RD) credit_used = credit_used + 32'd1;
    if (s2_valid && s2_kind == OP_HOST_RD) credit_used = credit_used + 32'd1;
  end

  assign req_ready = !rst0 && (state == IDLE) && (credit_used < RSP_DEPTH);
  assign accept    = req_valid && req_ready;
  assign fifo_push = s2_valid && (s2_kind == OP_HOST_RD);
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign busy      = (state != IDLE) || !sram_csb0 || s1_valid || s2_valid;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state      <= IDLE;
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      s1_valid   <= 1'b0;
      s1_kind    <= OP_HOST_RD;
      s2_valid   <= 1'b0;
      s2_kind    <= OP_HOST_RD;
      rmw_wdata  <= '0;
      rmw_wmask  <= '0;
    end else begin
      sram_csb0 <= 1'b1;
      sram_web0 <= 1'b1;
      s1_valid  <= 1'b0;
      s2_valid  <= s1_valid;
      s2_kind   <= s1_kind;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!req_we) begin
              sram_csb0  <= 1'b0;
              sram_addr0 <= req_addr;
              s1_valid   <= 1'b1;
              s1_kind    <= OP_HOST_RD;
            end else if (&req_wmask) begin
              sram_csb0  <= 1'b0;
              sram_web0  <= 1'b0;
              sram_addr0 <= req_addr;
              sram_din0  <= req_wdata;
            end else if (|req_wmask) begin
              sram_csb0  <= 1'b0;
              sram_addr0 <= req_addr;
              s1_valid   <= 1'b1;
              s1_kind    <= OP_RMW_RD;
              rmw_wdata  <= req_wdata;
              rmw_wmask  <= req_wmask;
              state      <= RMW_RD;
            end
          end
        end
        RMW_RD: state <= RMW_WAIT;
        RMW_WAIT: begin
          // Old word is merged straight off dout0 into the din0 register, so the
          // write can be driven the very next cycle; addr0 still holds the address.
          sram_din0 <= DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(sram_dout0),
                                               MERGE_MAX_W'(rmw_wdata),
                                               MERGE_MAX_B'(rmw_wmask)));
          sram_csb0 <= 1'b0;
          sram_web0 <= 1'b0;
          state     <= RMW_WR;
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk0      (clk0),
    .rst0      (rst0),
    .push      (fifo_push),
    .push_data (sram_dout0),
    .pop       (fifo_pop),
    .valid     (rsp_valid),
    .rdata     (rsp_rdata),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_32x8192_host_ctrl.sv
// Randomized self-checking bench: behavioural SRAM macro plus a cycle-indexed
// transaction model of the controller's externally visible behaviour.
module tb_sram_32x8192_host_ctrl;

  localparam int DEPTH = 4;

  logic        clk0 = 1'b0;
  logic        rst0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_wmask = '0;
  logic [12:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        sram_csb0;
  logic        sram_web0;
  logic [12:0] sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;

  sram_32x8192_host_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (13),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  always #5 clk0 = ~clk0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural macro ----------------
  logic [31:0] mac_mem [8192];
  logic        m_csb = 1'b1;
  logic        m_web = 1'b1;
  logic [12:0] m_addr;
  logic [31:0] m_din;
  logic        rd_v;
  logic [31:0] rd_val;
  int          mac_reads  = 0;
  int          mac_writes = 0;

  always @(negedge clk0) begin
    m_csb  = sram_csb0;
    m_web  = sram_web0;
    m_addr = sram_addr0;
    m_din  = sram_din0;
  end

  // Output is valid for one cycle after the sample edge, garbage otherwise.
  always @(posedge clk0) begin
    rd_v = 1'b0;
    if (!m_csb) begin
      if (!m_web) begin
        mac_mem[m_addr] = m_din;
        mac_writes++;
      end else begin
        rd_val = mac_mem[m_addr];
        rd_v   = 1'b1;
        mac_reads++;
      end
    end
    #1;
    sram_dout0 = rd_v ? rd_val : $urandom;
  end

  // ---------------- transaction model ----------------
  typedef struct { logic [31:0] data; int due; } rsp_t;
  typedef struct { bit we; logic [12:0] addr; logic [31:0] data; } op_t;

  logic [31:0] ref_mem [8192];
  rsp_t        q[$];
  op_t         exp_op[int];
  logic [31:0] rsp_log[$];
  bit          rv_hist[int];
  int          cyc = 0;
  bit          started = 1'b0;
  bit          rst_prev = 1'b0;
  int          rmw_until = -1;
  int          busy_until = -1;
  bit          pend_v = 1'b0;
  int          pend_c;
  logic [12:0] pend_addr;
  logic [31:0] pend_data;
  logic [12:0] hold_addr = '0;

  always @(negedge clk0) begin
    logic        exp_rdy;
    logic        exp_rv;
    logic [31:0] m32;
    op_t         op;
    exp_rdy = !rst0 && (cyc > rmw_until) && (q.size() < DEPTH);
    exp_rv  = (q.size() > 0) && (q[0].due <= cyc);
    if (started) begin
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) check("rsp_rdata", rsp_rdata, q[0].data);
      check("busy", 32'(busy), 32'(cyc <= busy_until));
      check("push_while_full", 32'(dut.fifo_push && (32'(dut.fifo_count) == DEPTH)), 32'd0);
      if (exp_op.exists(cyc)) begin
        op = exp_op[cyc];
        check("csb0_op", 32'(sram_csb0), 32'd0);
        check("web0_op", 32'(sram_web0), 32'(!op.we));
        hold_addr = op.addr;
        if (op.we) check("din0_write", sram_din0, op.data);
        exp_op.delete(cyc);
      end else begin
        check("csb0_idle", 32'(sram_csb0), 32'd1);
        check("web0_idle", 32'(sram_web0), 32'd1);
      end
      check("addr0", 32'(sram_addr0), 32'(hold_addr));
      if (rst_prev) check("din0_reset", sram_din0, 32'd0);
      rv_hist[cyc] = rsp_valid;
    end
    if (rst0) begin
      q.delete();
      for (int k = 1; k <= 3; k++) if (exp_op.exists(cyc + k)) exp_op.delete(cyc + k);
      rmw_until  = -1;
      busy_until = -1;
      hold_addr  = '0;
      if (pend_v && cyc <= pend_c + 2) pend_v = 1'b0;
      rst_prev = 1'b1;
      started  = 1'b1;
    end else if (started) begin
      rst_prev = 1'b0;
      if (pend_v && cyc == pend_c + 2) begin
        ref_mem[pend_addr] = pend_data;
        pend_v = 1'b0;
      end
      if (exp_rv && rsp_ready) begin
        rsp_log.push_back(q[0].data);
        void'(q.pop_front());
      end
      if (req_valid && exp_rdy) begin
        if (!req_we) begin
          q.push_back('{ref_mem[req_addr], cyc + 3});
          exp_op[cyc + 1] = '{1'b0, req_addr, 32'd0};
          if (cyc + 2 > busy_until) busy_until = cyc + 2;
        end else if (req_wmask == 4'hF) begin
          ref_mem[req_addr] = req_wdata;
          exp_op[cyc + 1] = '{1'b1, req_addr, req_wdata};
          if (cyc + 1 > busy_until) busy_until = cyc + 1;
        end else if (req_wmask != 4'h0) begin
          for (int b = 0; b < 4; b++) m32[8*b +: 8] = {8{req_wmask[b]}};
          pend_v    = 1'b1;
          pend_c    = cyc;
          pend_addr = req_addr;
          pend_data = (ref_mem[req_addr] & ~m32) | (req_wdata & m32);
          exp_op[cyc + 1] = '{1'b0, req_addr, 32'd0};
          exp_op[cyc + 3] = '{1'b1, req_addr, pend_data};
          rmw_until  = cyc + 3;
          busy_until = cyc + 3;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic issue(input bit we, input logic [3:0] mask, input logic [12:0] addr,
                       input logic [31:0] data, output int acc);
    req_valid = 1'b1;
    req_we    = we;
    req_wmask = mask;
    req_addr  = addr;
    req_wdata = data;
    acc = -1;
    for (int t = 0; t < 200 && acc < 0; t++) begin
      @(negedge clk0); #1;
      if (req_ready) acc = cyc - 1;
      @(posedge clk0); #1;
    end
    req_valid = 1'b0;
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk0); #1;
    end
  endtask

  bit rand_done = 1'b0;

  initial begin
    int          acc;
    int          f;
    int          n0;
    int          w0;
    logic [31:0] v;
    logic [3:0]  mk;
    for (int i = 0; i < 8192; i++) begin
      v = $urandom;
      mac_mem[i] = v;
      ref_mem[i] = v;
    end

    // Reset
    rst0 = 1'b1;
    @(negedge clk0); #1;
    check("rst_csb0", 32'(sram_csb0), 32'd1);
    check("rst_web0", 32'(sram_web0), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk0); #1;
    rst0 = 1'b0;
    @(negedge clk0); #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk0); #1;

    // Full write then read-back
    issue(1'b1, 4'hF, 13'h1234, 32'hDEADBEEF, acc);
    check("wr_csb0", 32'(sram_csb0), 32'd0);
    check("wr_web0", 32'(sram_web0), 32'd0);
    check("wr_din0", sram_din0, 32'hDEADBEEF);
    issue(1'b0, 4'h0, 13'h1234, 32'd0, acc);
    idle(1);
    check("rd_lat_early", 32'(rsp_valid), 32'd0);
    idle(1);
    check("rd_lat3_valid", 32'(rsp_valid), 32'd1);
    check("rd_lat3_data", rsp_rdata, 32'hDEADBEEF);
    idle(3);

    // Partial write (read-modify-write)
    n0 = mac_reads;
    w0 = mac_writes;
    issue(1'b1, 4'b0101, 13'h1234, 32'h11223344, acc);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk0); #1;
      check("rmw_ready_window", 32'(req_ready), (k == 4) ? 32'd1 : 32'd0);
      @(posedge clk0); #1;
    end
    check("rmw_macro_reads", 32'(mac_reads - n0), 32'd1);
    check("rmw_macro_writes", 32'(mac_writes - w0), 32'd1);
    check("rmw_model_pin", ref_mem[13'h1234], 32'hDE22BE44);
    issue(1'b0, 4'h0, 13'h1234, 32'd0, acc);
    idle(2);
    check("rmw_readback", rsp_rdata, 32'hDE22BE44);
    idle(3);

    // Back-pressure
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 4'h0, 13'(i), 32'd0, acc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk0); #1;
      check("bp_ready_low", 32'(req_ready), 32'd0);
      @(posedge clk0); #1;
    end
    n0 = rsp_log.size();
    rsp_ready = 1'b1;
    issue(1'b0, 4'h0, 13'd4, 32'd0, acc);
    issue(1'b0, 4'h0, 13'd5, 32'd0, acc);
    idle(8);
    check("bp_rsp_count", 32'(rsp_log.size() - n0), 32'd6);
    for (int i = 0; i < 6; i++)
      if (n0 + i < rsp_log.size()) check("bp_rsp_order", rsp_log[n0 + i], ref_mem[i]);

    // Streaming reads
    f = 0;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 4'h0, 13'($urandom_range(0, 8191)), 32'd0, acc);
      if (i == 0) f = acc;
      check("stream_accept", 32'(acc), 32'(f + i));
    end
    idle(4);
    check("stream_no_early", 32'(rv_hist.exists(f + 2) ? rv_hist[f + 2] : 1'b1), 32'd0);
    for (int c = f + 3; c <= f + 18; c++)
      check("stream_valid", 32'(rv_hist.exists(c) ? rv_hist[c] : 1'b0), 32'd1);

    // Randomized mix with random back-pressure
    fork
      begin
        while (!rand_done) begin
          @(posedge clk0); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       mk = 4'hF;
        1:       mk = 4'h0;
        default: mk = 4'($urandom);
      endcase
      issue(1'($urandom), mk, 13'($urandom_range(0, 15)), $urandom, acc);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rand_done = 1'b1;
    idle(2);
    rsp_ready = 1'b1;
    for (int t = 0; t < 50 && (q.size() != 0 || busy); t++) idle(1);
    check("drain_empty", 32'(q.size()), 32'd0);
    idle(2);

    // Reset during RMW_WAIT
    issue(1'b1, 4'b0011, 13'h40, 32'hA5A5A5A5, acc);
    idle(1);
    w0 = mac_writes;
    rst0 = 1'b1;
    idle(1);
    rst0 = 1'b0;
    check("rstmid_csb0", 32'(sram_csb0), 32'd1);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_fifo_empty", 32'(dut.fifo_count), 32'd0);
    idle(3);
    check("rstmid_no_write", 32'(mac_writes - w0), 32'd0);
    n0 = mac_reads + mac_writes;
    issue(1'b1, 4'h0, 13'h40, 32'hFFFFFFFF, acc);
    idle(3);
    check("mask0_no_activity", 32'(mac_reads + mac_writes - n0), 32'd0);
    issue(1'b0, 4'h0, 13'h40, 32'd0, acc);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
